muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply, restoring divide, MTHI/MTLO.
// Optional macro MULDIV_EARLY_TERM_EN ends multiply iterations once the remaining multiplier bits are zero.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

`ifdef MULDIV_EARLY_TERM_EN
  localparam logic EARLY_TERM = 1'b1;
`else
  localparam logic EARLY_TERM = 1'b0;
`endif

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic                 calc_last;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 div_zero;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     dq;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH:0]       shifted;
  logic                 ge;
  logic [WIDTH-1:0]     rem_step;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     q_fix;
  logic [WIDTH-1:0]     r_fix;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    magnitude = (sgn && x[WIDTH-1]) ? ((~x) + WIDTH'(1)) : x;
  endfunction

  assign mag_a = magnitude(a, op[0]);
  assign mag_b = magnitude(b, op[0]);

  // Next-state decode and end-of-iteration detection
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    calc_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !op[2]) begin
          accept     = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        calc_last = (cnt == CNT_W'(1)) ||
                    (EARLY_TERM && !is_div && ((mplier >> 1) == {WIDTH{1'b0}}));
        if (calc_last) begin
          state_next = FIX;
        end else begin
          state_next = CALC;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One iteration of each algorithm plus the sign-corrected final results
  always_comb begin
    shifted  = {rem, dq[WIDTH-1]};
    ge       = (shifted >= {1'b0, divisor});
    rem_step = ge ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    acc_step = mplier[0] ? (acc + mcand) : acc;
    prod_fix = neg_q ? ((~acc) + (2*WIDTH)'(1)) : acc;
    q_fix    = neg_q ? ((~dq) + WIDTH'(1)) : dq;
    r_fix    = neg_r ? ((~rem) + WIDTH'(1)) : rem;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand latching, iteration datapath and HI/LO / handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= {CNT_W{1'b0}};
      acc      <= {(2*WIDTH){1'b0}};
      mcand    <= {(2*WIDTH){1'b0}};
      mplier   <= {WIDTH{1'b0}};
      rem      <= {WIDTH{1'b0}};
      dq       <= {WIDTH{1'b0}};
      divisor  <= {WIDTH{1'b0}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy     <= 1'b1;
            is_div   <= op[1];
            neg_q    <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= op[0] & a[WIDTH-1];
            div_zero <= (b == {WIDTH{1'b0}});
            cnt      <= CNT_W'(WIDTH);
            acc      <= {(2*WIDTH){1'b0}};
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            mplier   <= mag_b;
            rem      <= {WIDTH{1'b0}};
            dq       <= mag_a;
            divisor  <= mag_b;
          end else if (start && (op == OP_MTHI)) begin
            hi <= a;
          end else if (start && (op == OP_MTLO)) begin
            lo <= a;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            rem <= rem_step;
            dq  <= {dq[WIDTH-2:0], ge};
          end else begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        FIX: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (is_div) begin
            // Divide by zero yields an all-ones quotient; remainder path already restores a
            lo <= div_zero ? {WIDTH{1'b1}} : q_fix;
            hi <= r_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Table-driven self-checking bench for muldiv_unit plus hand sequences for handshake corner cases.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] y);
`ifdef MULDIV_EARLY_TERM_EN
    logic [31:0] m;
    int bl;
`endif
    exp_lat = 34;
`ifdef MULDIV_EARLY_TERM_EN
    if (o == 3'd0 || o == 3'd1) begin
      m  = (o == 3'd1 && y[31]) ? (32'd0 - y) : y;
      bl = 1;
      for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
      exp_lat = bl + 2;
    end
`endif
  endfunction

  // Called just after a negedge; returns at the negedge following the accept edge.
  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op    = 3'd7;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Expects done at the lat-1'th negedge after entry, busy and stable hi/lo before that.
  task automatic wait_done(input int lat, input string nm);
    int          got;
    bit          busy_ok;
    bit          hold_ok;
    logic [31:0] hi0;
    logic [31:0] lo0;
    got     = -1;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    hi0     = hi;
    lo0     = lo;
    for (int n = 0; n < lat + 4; n++) begin
      if (done) begin
        got = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    chk({nm, " done_edge"}, 64'(got), 64'(lat - 1));
    chk({nm, " busy_during"}, 64'(busy_ok), 64'd1);
    chk({nm, " hilo_hold"}, 64'(hold_ok), 64'd1);
    chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit done_seen;

    vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'd1, 32'hFFFFFFFA, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{3'd0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
    vecs[5]  = '{3'd2, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[6]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8]  = '{3'd0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[9]  = '{3'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[10] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[11] = '{3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[12] = '{3'd2, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);

    for (int i = 0; i < 13; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(exp_lat(vecs[i].op, vecs[i].b), $sformatf("vec%0d", i));
      chk($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].lo));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
    end

    // MTHI / MTLO / undefined op after DIVU by zero left hi=12345678, lo=FFFFFFFF
    start_op(3'd4, 32'hCAFEBABE, 32'h0);
    chk("mthi hi", 64'(hi), 64'hCAFEBABE);
    chk("mthi lo", 64'(lo), 64'hFFFFFFFF);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    start_op(3'd5, 32'h0BADF00D, 32'h0);
    chk("mtlo lo", 64'(lo), 64'h0BADF00D);
    chk("mtlo hi", 64'(hi), 64'hCAFEBABE);
    start_op(3'd6, 32'h11111111, 32'h2);
    chk("undef hi", 64'(hi), 64'hCAFEBABE);
    chk("undef lo", 64'(lo), 64'h0BADF00D);
    chk("undef busy", 64'(busy), 64'd0);

    // Back-to-back: new start issued in the done cycle
    start_op(3'd0, 32'hFFFFFFFF, 32'h00000002);
    wait_done(exp_lat(3'd0, 32'h2), "b2b_first");
    chk("b2b_first hi", 64'(hi), 64'h1);
    chk("b2b_first lo", 64'(lo), 64'hFFFFFFFE);
    start_op(3'd0, 32'd3, 32'd5);
    wait_done(exp_lat(3'd0, 32'd5), "b2b_second");
    chk("b2b_second hi", 64'(hi), 64'h0);
    chk("b2b_second lo", 64'(lo), 64'd15);

    // start while busy is ignored; original DIVU completes on its schedule
    start_op(3'd2, 32'd100, 32'd7);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b1;
    op    = 3'd0;
    a     = 32'd3;
    b     = 32'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(34 - 5, "ignored_start");
    chk("ignored_start hi", 64'(hi), 64'd2);
    chk("ignored_start lo", 64'(lo), 64'd14);

    // Reset mid-operation: no done, everything cleared
    @(posedge clk);
    @(negedge clk);
    done_seen = 1'b0;
    start_op(3'd2, 32'h12345678, 32'd3);
    for (int n = 1; n <= 9; n++) begin
      start = (n == 5);
      op    = 3'd0;
      a     = 32'd9;
      b     = 32'd9;
      @(posedge clk);
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    start = 1'b0;
    chk("midop busy_before_reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midop reset busy", 64'(busy), 64'd0);
    chk("midop reset done", 64'(done), 64'd0);
    chk("midop reset hi", 64'(hi), 64'd0);
    chk("midop reset lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("midop no_done", 64'(done_seen), 64'd0);
    chk("midop idle busy", 64'(busy), 64'd0);
    chk("midop idle hi", 64'(hi), 64'd0);
    chk("midop idle lo", 64'(lo), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
